// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // wr_data = {device address (write form), register pointer, data byte}
  localparam int WD_DEV_MSB = 23;
  localparam int WD_DEV_LSB = 16;
  localparam int WD_REG_MSB = 15;
  localparam int WD_REG_LSB = 8;
  localparam int WD_DAT_MSB = 7;
  localparam int WD_DAT_LSB = 0;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes one raw bus line and debounces it; the filtered level only
// moves after FILTER_LEN consecutive synchronized samples disagree with it.
module i2c_line_filter
  import i2c_target_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic [3:0] cnt_q;
  logic       level_q;
  logic       prev_q;

  // Two-stage synchronizer; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], pin_i};
  end

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      prev_q <= level_q;
      if (sync_q[1] == level_q) begin
        cnt_q <= 4'd0;
      end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
        cnt_q   <= 4'd0;
        level_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;
  assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_adv_target_responder.sv
// I2C target mirroring the ADV7611 config master: writes become
// {dev, reg, data} words, reads are served from an external register source.
module i2c_adv_target_responder
  import i2c_target_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR   = 8'h98,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_valid,
  output logic [23:0] wr_data,
  output logic [7:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .pin_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .pin_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  i2c_state_e  state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shreg_q;     // bit 7 of a received byte is never needed after the 8th rise
  logic [6:0]  tx_q;        // MSB goes straight to sda_oe at load time
  logic [7:0]  reg_ptr_q;
  logic        rw_q;
  logic        done_q;      // read byte fully shifted, release on next fall
  logic        mack_q;      // master acked a read byte, reload on next fall
  logic        sda_oe_q;
  logic        wr_valid_q;
  logic [23:0] wr_data_q;
  logic        busy_q;

  logic       start_ev, stop_ev, last_bit, addr_match;
  logic [7:0] rx_byte;

  assign start_ev   = sda_fall & scl_lvl;
  assign stop_ev    = sda_rise & scl_lvl;
  assign rx_byte    = {shreg_q, sda_lvl};
  assign last_bit   = (bit_cnt_q == 3'd7);
  // General call (all-zero address) is never claimed.
  assign addr_match = (rx_byte[7:1] == DEV_ADDR[7:1]) && (rx_byte[7:1] != 7'd0);

  // Bus protocol FSM: bus conditions first, then SCL-edge bit handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 7'd0;
      tx_q       <= 7'd0;
      reg_ptr_q  <= 8'd0;
      rw_q       <= 1'b0;
      done_q     <= 1'b0;
      mack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= 24'd0;
      busy_q     <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      if (stop_ev) begin
        state_q   <= IDLE;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= 3'd0;
        done_q    <= 1'b0;
        mack_q    <= 1'b0;
      end else if (start_ev) begin
        state_q   <= ADDR;
        bit_cnt_q <= 3'd0;
        done_q    <= 1'b0;
        mack_q    <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          ADDR, REG, WR_DATA: begin
            shreg_q   <= rx_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              case (state_q)
                ADDR: begin
                  if (addr_match) begin
                    state_q <= ADDR_ACK;
                    rw_q    <= rx_byte[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                  end
                end
                REG: begin
                  reg_ptr_q <= rx_byte;
                  state_q   <= REG_ACK;
                end
                default: begin
                  wr_valid_q <= 1'b1;
                  wr_data_q[WD_DEV_MSB:WD_DEV_LSB] <= {DEV_ADDR[7:1], 1'b0};
                  wr_data_q[WD_REG_MSB:WD_REG_LSB] <= reg_ptr_q;
                  wr_data_q[WD_DAT_MSB:WD_DAT_LSB] <= rx_byte;
                  state_q <= WR_ACK;
                end
              endcase
            end
          end
          RD_DATA: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) done_q <= 1'b1;
          end
          RD_ACK: begin
            // Advance early so rd_data settles well before the reload fall.
            if (sda_lvl == I2C_ACK) begin
              reg_ptr_q <= reg_ptr_q + 8'd1;
              mack_q    <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          ADDR: sda_oe_q <= 1'b0;
          ADDR_ACK, REG_ACK, WR_ACK: begin
            // First fall starts the ACK bit, second fall ends it.
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              case (state_q)
                ADDR_ACK: begin
                  if (rw_q) begin
                    tx_q     <= rd_data[6:0];
                    sda_oe_q <= ~rd_data[7];
                    state_q  <= RD_DATA;
                  end else begin
                    state_q <= REG;
                  end
                end
                REG_ACK: state_q <= WR_DATA;
                default: begin
                  reg_ptr_q <= reg_ptr_q + 8'd1;
                  state_q   <= WR_DATA;
                end
              endcase
            end
          end
          RD_DATA: begin
            if (done_q) begin
              done_q   <= 1'b0;
              sda_oe_q <= 1'b0;
              state_q  <= RD_ACK;
            end else begin
              sda_oe_q <= ~tx_q[6];
              tx_q     <= {tx_q[5:0], 1'b0};
            end
          end
          RD_ACK: begin
            if (mack_q) begin
              mack_q   <= 1'b0;
              tx_q     <= rd_data[6:0];
              sda_oe_q <= ~rd_data[7];
              state_q  <= RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = reg_ptr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_adv_target_responder.sv
// Directed bench: bit-banged I2C master, open-drain bus, write scoreboard.
module tb_i2c_adv_target_responder;
  import i2c_target_pkg::*;

  localparam int Q  = 10;  // quarter SCL period in clk
  localparam int FL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, wr_valid, busy;
  logic [23:0] wr_data;
  logic [7:0]  rd_addr, rd_data;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  // Register source model
  always_comb begin
    case (rd_addr)
      8'h05:   rd_data = 8'hA0;
      8'h06:   rd_data = 8'hA1;
      default: rd_data = ~rd_addr;
    endcase
  end

  i2c_adv_target_responder #(.DEV_ADDR(8'h98), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  // Observed-write capture and activity counters
  logic [23:0] obs_mem [0:63];
  int obs_wr = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (wr_valid) begin
      obs_mem[obs_wr[5:0]] <= wr_data;
      obs_wr <= obs_wr + 1;
    end
    oe_cnt   <= oe_cnt + int'(sda_oe);
    busy_cnt <= busy_cnt + int'(busy);
  end

  int n_cmp = 0;
  int n_err = 0;
  int rd_idx = 0;
  logic [23:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pop every captured write against the expected queue.
  task automatic drain();
    while (rd_idx != obs_wr) begin
      if (exp_q.size() == 0) chk("wr_spurious", 32'(exp_q.size()), 32'd1);
      else                   chk("wr_data", {8'h0, obs_mem[rd_idx[5:0]]}, {8'h0, exp_q.pop_front()});
      rd_idx++;
    end
  endtask

  // One SCL period; optional short SCL glitch during the low phase.
  task automatic bit_x(input logic b, input int g, output logic r);
    sda_m = b;
    tick(3);
    if (g > 0) begin
      scl_m = 1'b1; tick(g); scl_m = 1'b0;
    end
    tick(Q - 3 - g);
    scl_m = 1'b1; tick(Q);
    r = sda_bus;  tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, input logic glitch, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--)
      bit_x(d[i], !glitch ? 0 : (i == 6) ? 1 : (i == 3) ? FL - 1 : 0, r);
    bit_x(1'b1, 0, ack);
  endtask

  task automatic wack(input logic [7:0] d, input string tag);
    logic a;
    wbyte(d, 1'b0, a);
    chk(tag, 32'(a), 32'(I2C_ACK));
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, 0, r);
      d[i] = r;
    end
    bit_x(mack, 0, r);
  endtask

  task automatic test_write1(input string p);
    int w0;
    w0 = obs_wr;
    exp_q.push_back(24'h98F480);
    start_c();
    wack(8'h98, {p, "_ack_addr"});
    wack(8'hF4, {p, "_ack_reg"});
    wack(8'h80, {p, "_ack_data"});
    chk({p, "_busy_mid"}, 32'(busy), 32'd1);
    stop_c();
    drain();
    chk({p, "_wr_count"}, 32'(obs_wr - w0), 32'd1);
    chk({p, "_busy_after_stop"}, 32'(busy), 32'd0);
    chk({p, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic       a, r;
    logic [7:0] d;
    int         oe0, busy0, w0;

    // Reset state
    tick(5);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_data", {8'h0, wr_data}, 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(10);

    // 1: single write
    test_write1("t1");

    // 2: foreign address ignored
    oe0 = oe_cnt; busy0 = busy_cnt; w0 = obs_wr;
    start_c();
    wbyte(8'h68, 1'b0, a);
    chk("t2_nack_addr", 32'(a), 32'(I2C_NACK));
    wbyte(8'h40, 1'b0, a);
    stop_c();
    tick(2);
    drain();
    chk("t2_oe_never", 32'(oe_cnt - oe0), 32'd0);
    chk("t2_busy_never", 32'(busy_cnt - busy0), 32'd0);
    chk("t2_no_write", 32'(obs_wr - w0), 32'd0);

    // 3: burst with pointer wrap
    exp_q.push_back(24'h98FE11);
    exp_q.push_back(24'h98FF22);
    exp_q.push_back(24'h980033);
    start_c();
    wack(8'h98, "t3_ack_addr");
    wack(8'hFE, "t3_ack_reg");
    wack(8'h11, "t3_ack_d0");
    wack(8'h22, "t3_ack_d1");
    wack(8'h33, "t3_ack_d2");
    stop_c();
    drain();
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: pointer set, repeated start, two-byte read
    start_c();
    wack(8'h98, "t4_ack_addr");
    wack(8'h05, "t4_ack_reg");
    chk("t4_rd_addr", 32'(rd_addr), 32'h05);
    start_c();
    wack(8'h99, "t4_ack_raddr");
    rbyte(I2C_ACK, d);
    chk("t4_rd_byte0", 32'(d), 32'hA0);
    rbyte(I2C_NACK, d);
    chk("t4_rd_byte1", 32'(d), 32'hA1);
    chk("t4_released", 32'(sda_oe), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    stop_c();

    // 5: SCL glitches during a data byte
    exp_q.push_back(24'h98105A);
    start_c();
    wack(8'h98, "t5_ack_addr");
    wack(8'h10, "t5_ack_reg");
    wbyte(8'h5A, 1'b1, a);
    chk("t5_ack_data", 32'(a), 32'(I2C_ACK));
    stop_c();
    drain();
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset during bit 4 of a read (0xA1 -> bit 4 is 0, so SDA is held)
    start_c();
    wack(8'h98, "t6_ack_addr");
    wack(8'h06, "t6_ack_reg");
    start_c();
    wack(8'h99, "t6_ack_raddr");
    for (int i = 0; i < 3; i++) bit_x(1'b1, 0, r);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    chk("t6_oe_before_rst", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_oe_async", 32'(sda_oe), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    chk("t6_rd_addr_async", 32'(rd_addr), 32'd0);
    tick(5);
    rst = 1'b0;
    tick(10);
    test_write1("t6w");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_adv_target_responder.md
Name: i2c_adv_target_responder

Overview:
I2C target (slave) that acts as the far end of the ADV7611 configuration master. It is used as a bench/loopback model and as an on-FPGA register mirror. It decodes write transactions into the same 24-bit {dev_addr, reg, data} word format the config LUTs produce, and it serves read transactions from an external 8-bit register source. SCL/SDA are oversampled on the system clock. The block drives SDA low only: open-drain, no clock stretching.

Parameters:
DEV_ADDR, 8'h98, 8-bit write-form device address responded to; bit0 is ignored when matching.
FILTER_LEN, 3, consecutive equal samples required before a filtered SCL/SDA level changes (range 1..15).

Ports:
clk  input  1  system clock, at least 10x SCL rate
rst  input  1  asynchronous, active-high reset
scl_i  input  1  raw SCL pin level
sda_i  input  1  raw SDA pin level
sda_oe  output  1  1 = pull SDA low; 0 = release
wr_valid  output  1  one-clk strobe: a write byte has been accepted
wr_data  output  24  {DEV_ADDR[7:1],1'b0, reg_ptr, data_byte}; valid while wr_valid=1
rd_addr  output  8  register pointer presented to the read source
rd_data  input  8  register contents for rd_addr; must be stable within 2 clk of a rd_addr change
busy  output  1  1 from an address-matched START until STOP or return to IDLE

Behaviour:
- Reset values: sda_oe=0, wr_valid=0, wr_data=0, rd_addr=0, busy=0, state=IDLE, filtered SCL/SDA=1.
- Input path: 2-FF synchronizer, then filter. Latency from pin to filtered level = 2+FILTER_LEN clk. Pulses shorter than FILTER_LEN clk are rejected.
- Events, from the filtered signals:
  - scl_rise / scl_fall: edges of SCL.
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
- Sampling rules: SDA is sampled on scl_rise. sda_oe changes only on scl_fall, except that STOP and reset release it immediately.
- States:
  - IDLE: on START -> ADDR.
  - ADDR: shift 8 bits MSB first. After the 8th bit:
    - match on [7:1] -> ADDR_ACK.
    - mismatch -> IDLE; no ACK, nothing further happens until the next START.
  - ADDR_ACK: drive ACK for one SCL period. Then R/W=0 -> REG; R/W=1 -> RD_DATA.
  - REG: shift 8 bits into reg_ptr; rd_addr follows reg_ptr. Then -> REG_ACK (always ACK) -> WR_DATA.
  - WR_DATA: shift 8 bits. On the 8th scl_rise, pulse wr_valid the following clk with the current reg_ptr. Then -> WR_ACK (ACK) -> WR_DATA. reg_ptr increments on the scl_fall that ends WR_ACK.
  - RD_DATA: the tx shift register loads rd_data on the scl_fall that ends ADDR_ACK or RD_ACK. Shift out MSB first: drive 0 bits, release on 1 bits. Then -> RD_ACK.
  - RD_ACK: sample the master's bit and release SDA.
    - ACK (0): reg_ptr++ -> RD_DATA.
    - NACK (1): -> IDLE.
- Pointer: reg_ptr is 8-bit and wraps 8'hFF -> 8'h00 in both directions. It persists across transactions, so a read following a write-only pointer set uses it.
- Event priority and boundaries:
  - STOP in any state -> IDLE and sda_oe=0. A partial byte is discarded with no wr_valid.
  - A repeated START in any state -> ADDR; reg_ptr is kept.
  - START and STOP detection take priority over bit shifting in the same clk.
  - rst asserted mid-byte: all outputs return to reset values asynchronously, and the bus is released.
  - General call address (0x00) is not acknowledged.

Decomposition:
- Package i2c_target_pkg holds:
  - state enum: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - constants I2C_ACK=1'b0 and I2C_NACK=1'b1.
  - the wr_data field-slice localparams.
- Sub-module i2c_line_filter (param FILTER_LEN): 2-FF sync, saturating counter, filtered level, rise/fall strobes. It is instantiated once for SCL and once for SDA.

Test Plan:
1. START, 0x98, 0xF4, 0x80, STOP -> ACK on all three bytes; exactly one wr_valid with wr_data=24'h98F480; busy falls on STOP.
2. START, 0x68, 0x40, STOP with DEV_ADDR=8'h98 -> sda_oe never asserts; no wr_valid; busy stays 0.
3. Burst START, 0x98, 0xFE, 0x11, 0x22, 0x33, STOP -> wr_data sequence 98FE11, 98FF22, 980033 (pointer wraps).
4. Write pointer 0x05, repeated START, 0x99, read 2 bytes (master ACK, then NACK) with the source returning 0xA0/0xA1 for addr 05/06 -> SDA carries 0xA0 then 0xA1; SDA released after the NACK; state IDLE.
5. 1-clk and (FILTER_LEN-1)-clk glitches on SCL during a data byte -> no extra bit shifted; byte 0x5A decoded correctly.
6. Assert rst during bit 4 of a read while sda_oe=1 -> sda_oe=0 asynchronously. The next full write (test 1) completes normally.
